uart_receiver: RTL

Receive half of the board's 8N1 serial link: it deserialises bytes arriving on the `RxD` pin into parallel data for the capture and control logic. It is the counterpart of the existing transmitter and shares its `ClkFrequency` and `Baud` parameters. The `RxD` line is oversampled, each start bit is validated at mid-bit, and every bit is sampled at its centre. Each received byte is presented with a one-cycle strobe, and a bad stop bit is flagged.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_receiver_if.sv | 29 ++
 rtl/uart_os_tick_gen.sv | 31 +++
 rtl/uart_receiver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  // Board defaults, kept identical on both halves of the link.
  localparam int UART_CLK_FREQ_DEFAULT = 50000000;
  localparam int UART_BAUD_DEFAULT     = 9600;

  // Clocks per oversampling tick, rounded to nearest and never below 1.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    int denom;
    int q;
    denom = baud * os;
    q = (clk_hz + denom / 2) / denom;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial input plus the parallel byte/strobe side of the receiver.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                      RxD;
  logic [UART_DATA_BITS-1:0] RxD_data;
  logic                      RxD_data_ready;
  logic                      RxD_frame_error;
  logic                      RxD_busy;

  // Line driver / consumer side.
  modport master (
    output RxD,
    input  RxD_data,
    input  RxD_data_ready,
    input  RxD_frame_error,
    input  RxD_busy
  );

  // Receiver side.
  modport slave (
    input  RxD,
    output RxD_data,
    output RxD_data_ready,
    output RxD_frame_error,
    output RxD_busy
  );

endinterface

// File: rtl/uart_os_tick_gen.sv
// Free-running divider producing the oversampling tick for the receiver.
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int ClkFrequency = UART_CLK_FREQ_DEFAULT,
  parameter int Baud         = UART_BAUD_DEFAULT,
  parameter int Oversampling = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV   = uart_div(ClkFrequency, Baud, Oversampling);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count of each period, then restart from zero.
  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Divider counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 receiver: synchronises RxD, validates the start bit at mid-bit and
// samples every following bit at its centre using the oversampling tick.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int ClkFrequency = UART_CLK_FREQ_DEFAULT,
  parameter int Baud         = UART_BAUD_DEFAULT,
  parameter int Oversampling = 16
) (
  input logic          clk,
  input logic          rst,
  uart_receiver_if.slave rx
);

  localparam int OS_W = $clog2(Oversampling);

  logic os_tick;

  uart_os_tick_gen #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud),
    .Oversampling(Oversampling)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(os_tick)
  );

  uart_state_e               state_q, state_d;
  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic [1:0]                fill_q, fill_d;
  logic                      armed_q, armed_d;
  logic [OS_W-1:0]           os_cnt_q, os_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      ready_q, ready_d;
  logic                      ferr_q, ferr_d;
  logic                      rxd_s;
  logic                      sync_valid;
  logic                      os_wrap;

  assign rxd_s      = sync2_q;
  // The synchroniser resets to 1, so its output only reflects the real line
  // once both stages have been refilled; arming before that would let a line
  // held low through reset look like a fresh start edge.
  assign sync_valid = fill_q[1];
  assign os_wrap    = (os_cnt_q == OS_W'(Oversampling - 1));

  // Synchroniser shift and arming flag.
  always_comb begin
    sync1_d = rx.RxD;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (sync_valid & rxd_s);
  end

  // Frame FSM: next state, counters, shift register and registered strobes.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (os_tick && armed_q && !rxd_s) begin
          os_cnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (os_tick) begin
          if (os_cnt_q == OS_W'(Oversampling / 2 - 2)) begin
            if (!rxd_s) begin
              os_cnt_d  = '0;
              bit_idx_d = '0;
              state_d   = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_wrap) begin
            shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
            else                                     bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_wrap) begin
            if (rxd_s) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx.RxD_data        = data_q;
  assign rx.RxD_data_ready  = ready_q;
  assign rx.RxD_frame_error = ferr_q;
  assign rx.RxD_busy        = (state_q == DATA) || (state_q == STOP) || (state_q == BREAK);

endmodule
